control_fifo_data_in_mc: RTL and testbench
==========================================

// Module: control_fifo_data_in_mc
// PURPOSE
//  Multi-channel successor of the single-ID input-FIFO writer. Sits between the shared host input stream and NUM_CH per-PE input FIFOs.
//  Decodes the low ID_WIDTH bits of each word as a destination ID. Words whose ID is in [ID_BASE, ID_BASE+NUM_CH) are routed to the matching FIFO; all other words are dropped.
//  Adds a one-word skid slot per channel and upstream backpressure (data_in_ready), so a full FIFO stalls the stream instead of losing data.
// PARAMETERS
//  ID_WIDTH    6    width of the ID field, data_in[ID_WIDTH-1:0]
//  DATA_WIDTH  376  payload width, data_in[ID_WIDTH+DATA_WIDTH-1:ID_WIDTH]
//  NUM_CH      4    number of output FIFO channels, 1..16
//  ID_BASE     0    ID mapped to channel 0; channel c owns ID_BASE+c
//  CNT_WIDTH   32   width of the statistics counters (CTRL_FIFO_STATS_EN only)
// PORTS
//  clk                 in   1                  clock, all logic on the rising edge
//  rst                 in   1                  synchronous reset, ACTIVE-LOW (rst==0 resets)
//  start               in   1                  enables acceptance of new input words
//  data_in_valid       in   1                  input word valid
//  data_in             in   ID_WIDTH+DATA_WIDTH  {payload, id}
//  data_in_ready       out  1                  block can accept a word this cycle
//  fifo_in_full        in   NUM_CH             per-channel FIFO full
//  fifo_in_amostfull   in   NUM_CH             per-channel almost-full (<=1 free slot)
//  fifo_in_we          out  NUM_CH             per-channel write enable, registered
//  fifo_in_data        out  NUM_CH*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH], registered
//  accepted_count      out  CNT_WIDTH          words written to any FIFO (CTRL_FIFO_STATS_EN only)
//  dropped_count       out  CNT_WIDTH          words with an unmapped ID (CTRL_FIFO_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst==0): fifo_in_we=0, fifo_in_data=0, all skid slots EMPTY, data_in_ready=0, counters=0.
//    Reset mid-operation discards any skid content; no write is issued in the cycle after reset.
//  - Combinational: data_in_ready = rst & start & (no channel in state HOLD).
//  - Accept: data_in_valid & data_in_ready. In that cycle id = data_in[ID_WIDTH-1:0], c = id - ID_BASE.
//  - Unmapped id (id<ID_BASE or id>=ID_BASE+NUM_CH): word consumed, no write, dropped_count++.
//  - Mapped id, channel c EMPTY and fifo_in_amostfull[c]==0:
//    next cycle fifo_in_we[c]=1 and fifo_in_data[c]=payload. Latency 1.
//  - Mapped id, channel c EMPTY and fifo_in_amostfull[c]==1: payload captured in skid[c]; state -> HOLD.
//  - Per-channel FSM: EMPTY -> HOLD as above. HOLD -> EMPTY when fifo_in_full[c]==0 and fifo_in_amostfull[c]==0,
//    which issues fifo_in_we[c]=1 with the skid payload on the next cycle.
//  - The skid drains independently of start; start=0 blocks only new accepts.
//  - fifo_in_we is a 1-cycle pulse per word and is 0 by default every cycle.
//    fifo_in_data[c] holds its last written value.
//  - At most one channel is written per cycle (one input word per cycle).
//    A drain on c and a direct write on d!=c cannot coincide, because ready is 0 while any channel is in HOLD.
//  - fifo_in_we[c] is never asserted while fifo_in_full[c]==1 was sampled in the deciding cycle.
//  - data_in_valid while data_in_ready==0: word not consumed, upstream must hold it stable.
//  - Counters wrap modulo 2^CNT_WIDTH. accepted_count increments on each fifo_in_we pulse.
// CONFIGURATION
//  - CTRL_FIFO_STATS_EN defined: accepted_count and dropped_count ports plus their registers exist.
//  - Undefined: the ports and counter logic are absent. The data path and timing are identical.
// STRUCTURE
//  - Shared package control_fifo_pkg: ID_WIDTH and DATA_WIDTH defaults, skid-slot state encoding (EMPTY=0, HOLD=1),
//    and a function that computes channel index and in-range flag from an id.
//  - Sub-module control_fifo_skid_slot (one per channel, generate loop): holds the EMPTY/HOLD state and the payload register,
//    and produces we/data for its channel. The top level holds the ID decode, ready logic and counters.
// TESTING
//  1. NUM_CH=4, ID_BASE=8; send ids 8,9,10,11 back-to-back with all FIFOs empty ->
//     fifo_in_we one-hot 0001,0010,0100,1000 on cycles 1..4; data matches; ready stays 1.
//  2. Send id 3 and id 12 -> no fifo_in_we; dropped_count=2, accepted_count=0.
//  3. amostfull[1]=1, send id 9 -> skid[1]=HOLD and ready=0 next cycle. Release amostfull after 5 cycles ->
//     one we[1] pulse with the original payload, then ready=1.
//  4. Hold start=0 with valid=1 -> ready=0 and no writes. A pending HOLD still drains when the FIFO frees.
//  5. rst=0 asserted while channel 2 in HOLD -> after reset all we=0 and ready follows start; the held word is never written.
//  6. Random ids and random full/amostfull for 10k cycles vs scoreboard -> no loss, no duplication, order preserved per channel.

Source files
------------

// File: rtl/control_fifo_pkg.sv
// Shared definitions for the multi-channel input-FIFO writer.
//  - Default ID and payload widths.
//  - Skid-slot state encoding (EMPTY=0, HOLD=1).
//  - decode_id(): maps a destination id onto a channel index plus an in-range flag.
package control_fifo_pkg;

  localparam int unsigned ID_WIDTH_DEF   = 6;
  localparam int unsigned DATA_WIDTH_DEF = 376;
  // Wide enough to index up to 16 channels.
  localparam int unsigned CH_IDX_WIDTH   = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HOLD  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic                    hit;
    logic [CH_IDX_WIDTH-1:0] ch;
  } id_decode_t;

  // Channel c owns id base+c. The offset is taken first, so ids below base
  // wrap to a large value and fail the range test.
  function automatic id_decode_t decode_id(
    input logic [31:0] id,
    input logic [31:0] base,
    input logic [31:0] num_ch
  );
    id_decode_t  res;
    logic [31:0] off;
    off     = id - base;
    res.hit = (id >= base) && (off < num_ch);
    if (res.hit) begin
      res.ch = off[CH_IDX_WIDTH-1:0];
    end else begin
      res.ch = 4'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/control_fifo_skid_slot.sv
// One-word skid slot for a single output FIFO channel.
// Ports:
//  clk, rst        clock; synchronous active-low reset
//  wr              a word for this channel is accepted this cycle
//  payload         payload of that word
//  full, amostfull FIFO status of this channel
//  hold            slot holds a word waiting for FIFO space
//  we, data        registered FIFO write strobe and write data
module control_fifo_skid_slot
  import control_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] payload,
  input  logic                  full,
  input  logic                  amostfull,
  output logic                  hold,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] data
);

  slot_state_e           state_r, state_nx_s;
  logic [DATA_WIDTH-1:0] skid_r, skid_nx_s;
  logic                  we_r, we_nx_s;
  logic [DATA_WIDTH-1:0] data_r, data_nx_s;
  logic                  blocked_s;

  // Full is folded in with almost-full so a write can never target a full
  // FIFO, even if the two status bits are momentarily inconsistent.
  assign blocked_s = full | amostfull;

  // Slot state, skid payload and registered FIFO write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= SLOT_EMPTY;
      skid_r  <= '0;
      we_r    <= 1'b0;
      data_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      skid_r  <= skid_nx_s;
      we_r    <= we_nx_s;
      data_r  <= data_nx_s;
    end
  end

  // Next-state: write through when the FIFO has room, otherwise park the
  // word and drain it once the FIFO reports space again.
  always_comb begin
    state_nx_s = state_r;
    skid_nx_s  = skid_r;
    we_nx_s    = 1'b0;
    data_nx_s  = data_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (wr && blocked_s) begin
          skid_nx_s  = payload;
          state_nx_s = SLOT_HOLD;
        end else if (wr) begin
          we_nx_s    = 1'b1;
          data_nx_s  = payload;
        end else begin
          state_nx_s = SLOT_EMPTY;
        end
      end
      SLOT_HOLD: begin
        if (!blocked_s) begin
          we_nx_s    = 1'b1;
          data_nx_s  = skid_r;
          state_nx_s = SLOT_EMPTY;
        end else begin
          state_nx_s = SLOT_HOLD;
        end
      end
      default: begin
        state_nx_s = SLOT_EMPTY;
      end
    endcase
  end

  assign hold = (state_r == SLOT_HOLD);
  assign we   = we_r;
  assign data = data_r;

endmodule

// File: rtl/control_fifo_data_in_mc.sv
// Multi-channel input-FIFO writer. Decodes the low ID_WIDTH bits of each
// host word as a destination id and routes ids ID_BASE..ID_BASE+NUM_CH-1 to
// per-channel FIFOs through one-word skid slots; other ids are dropped.
// Upstream is stalled (data_in_ready=0) while any slot holds a word.
// Ports:
//  clk, rst           clock; synchronous active-low reset
//  start              enables acceptance of new words
//  data_in_valid/data_in/data_in_ready   host stream, data_in = {payload, id}
//  fifo_in_full/fifo_in_amostfull        per-channel FIFO status
//  fifo_in_we/fifo_in_data               per-channel registered write port
//  accepted_count/dropped_count          statistics (CTRL_FIFO_STATS_EN only)
// Build option: define CTRL_FIFO_STATS_EN to add the statistics counters.
module control_fifo_data_in_mc
  import control_fifo_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ID_BASE    = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           data_in_valid,
  input  logic [ID_WIDTH+DATA_WIDTH-1:0] data_in,
  output logic                           data_in_ready,
  input  logic [NUM_CH-1:0]              fifo_in_full,
  input  logic [NUM_CH-1:0]              fifo_in_amostfull,
  output logic [NUM_CH-1:0]              fifo_in_we,
  output logic [NUM_CH*DATA_WIDTH-1:0]   fifo_in_data
`ifdef CTRL_FIFO_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]           accepted_count,
  output logic [CNT_WIDTH-1:0]           dropped_count
`endif
);

  logic [31:0]           id_ext_s;
  id_decode_t            dec_s;
  logic [DATA_WIDTH-1:0] payload_s;
  logic                  accept_s;
  logic [NUM_CH-1:0]     wr_s;
  logic [NUM_CH-1:0]     hold_s;

  assign id_ext_s  = 32'(data_in[ID_WIDTH-1:0]);
  assign payload_s = data_in[ID_WIDTH+DATA_WIDTH-1:ID_WIDTH];
  assign dec_s     = decode_id(id_ext_s, 32'(ID_BASE), 32'(NUM_CH));

  // Any held word blocks the whole stream, which also guarantees that a
  // drain and a direct write never land in the same cycle.
  assign data_in_ready = rst & start & ~(|hold_s);
  assign accept_s      = data_in_valid & data_in_ready;

  // One-hot channel select for the accepted word.
  always_comb begin
    wr_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept_s && dec_s.hit && (dec_s.ch == CH_IDX_WIDTH'(c))) begin
        wr_s[c] = 1'b1;
      end else begin
        wr_s[c] = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    control_fifo_skid_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .wr        (wr_s[c]),
      .payload   (payload_s),
      .full      (fifo_in_full[c]),
      .amostfull (fifo_in_amostfull[c]),
      .hold      (hold_s[c]),
      .we        (fifo_in_we[c]),
      .data      (fifo_in_data[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef CTRL_FIFO_STATS_EN
  logic [CNT_WIDTH-1:0] accepted_r;
  logic [CNT_WIDTH-1:0] dropped_r;

  // Statistics: writes issued and unmapped words consumed, wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      accepted_r <= '0;
      dropped_r  <= '0;
    end else begin
      if (|fifo_in_we) begin
        accepted_r <= accepted_r + CNT_WIDTH'(1);
      end
      if (accept_s && !dec_s.hit) begin
        dropped_r <= dropped_r + CNT_WIDTH'(1);
      end
    end
  end

  assign accepted_count = accepted_r;
  assign dropped_count  = dropped_r;
`endif

endmodule

// File: tb/tb_control_fifo_data_in_mc.sv
module tb_control_fifo_data_in_mc;

  localparam int IDW = 6;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int IDB = 8;
  localparam int CW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              data_in_valid;
  logic [IDW+DW-1:0] data_in;
  logic              data_in_ready;
  logic [NCH-1:0]    fifo_in_full;
  logic [NCH-1:0]    fifo_in_amostfull;
  logic [NCH-1:0]    fifo_in_we;
  logic [NCH*DW-1:0] fifo_in_data;
`ifdef CTRL_FIFO_STATS_EN
  logic [CW-1:0]     accepted_count;
  logic [CW-1:0]     dropped_count;
`endif

  control_fifo_data_in_mc #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .NUM_CH(NCH), .ID_BASE(IDB), .CNT_WIDTH(CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .data_in_valid     (data_in_valid),
    .data_in           (data_in),
    .data_in_ready     (data_in_ready),
    .fifo_in_full      (fifo_in_full),
    .fifo_in_amostfull (fifo_in_amostfull),
    .fifo_in_we        (fifo_in_we),
    .fifo_in_data      (fifo_in_data)
`ifdef CTRL_FIFO_STATS_EN
    ,
    .accepted_count    (accepted_count),
    .dropped_count     (dropped_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [5:0]  id;
    logic [31:0] payload;
    logic [3:0]  exp_we;
  } vec_t;
  vec_t vecs[4];

  logic [NCH-1:0] prev_full = '0;
  int exp_drop = 0;
  int exp_acc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mapped(input logic [5:0] id);
    return (id >= 6'(IDB)) && (id < 6'(IDB + NCH));
  endfunction

  // Scoreboard monitor: every write must match the oldest expected word of its channel.
  always @(negedge clk) begin
    if (fifo_in_we != '0) begin
      check("we_onehot", 64'($onehot(fifo_in_we)), 64'd1);
      for (int c = 0; c < NCH; c++) begin
        if (fifo_in_we[c] === 1'b1) begin
          int idx;
          idx = -1;
          check("we_while_full", 64'(prev_full[c]), 64'd0);
          for (int i = 0; i < sbq.size(); i++) begin
            if (idx < 0 && sbq[i].ch == c) idx = i;
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: ch %0d data %0h, no word expected", c, fifo_in_data[c*DW +: DW]);
          end else begin
            check("write_data", 64'(fifo_in_data[c*DW +: DW]), 64'(sbq[idx].data));
            sbq.delete(idx);
          end
        end
      end
    end
    prev_full = fifo_in_full;
  end

  task automatic do_reset();
    rst = 1'b0;
    data_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sbq.delete();
    exp_drop = 0;
    exp_acc  = 0;
    rst = 1'b1;
  endtask

  task automatic drive(input logic [5:0] id, input logic [31:0] pay);
    data_in_valid = 1'b1;
    data_in = {pay, id};
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit have_word;
    logic [5:0]  cur_id;
    logic [31:0] cur_pay;

    vecs[0] = '{6'd8,  32'hA000_0008, 4'b0001};
    vecs[1] = '{6'd9,  32'hB111_0009, 4'b0010};
    vecs[2] = '{6'd10, 32'hC222_000A, 4'b0100};
    vecs[3] = '{6'd11, 32'hD333_000B, 4'b1000};

    rst = 1'b0; start = 1'b1; data_in_valid = 1'b0; data_in = '0;
    fifo_in_full = '0; fifo_in_amostfull = '0;

    // Reset state (start=1 so ready must be gated by rst)
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_we", 64'(fifo_in_we), 64'd0);
    check("reset_data", 64'(|fifo_in_data), 64'd0);
    check("reset_ready", 64'(data_in_ready), 64'd0);
`ifdef CTRL_FIFO_STATS_EN
    check("reset_acc", 64'(accepted_count), 64'd0);
    check("reset_drop", 64'(dropped_count), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(data_in_ready), 64'd1);
    @(posedge clk); #1;

    // Test 1: back-to-back ids 8..11
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].id, vecs[i].payload);
      sbq.push_back('{int'(vecs[i].id) - IDB, vecs[i].payload});
      @(negedge clk);
      check("t1_ready", 64'(data_in_ready), 64'd1);
      check("t1_we", 64'(fifo_in_we), (i == 0) ? 64'd0 : 64'(vecs[i-1].exp_we));
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    @(negedge clk);
    check("t1_we_last", 64'(fifo_in_we), 64'(vecs[3].exp_we));
    @(posedge clk); #1;

    // Test 2: unmapped ids are dropped
    do_reset();
    drive(6'd3, 32'h3333_3333);
    @(negedge clk);
    check("t2_ready_a", 64'(data_in_ready), 64'd1);
    @(posedge clk); #1;
    drive(6'd12, 32'h1212_1212);
    @(negedge clk);
    check("t2_we_a", 64'(fifo_in_we), 64'd0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("t2_we_b", 64'(fifo_in_we), 64'd0);
`ifdef CTRL_FIFO_STATS_EN
    check("t2_drop", 64'(dropped_count), 64'd2);
    check("t2_acc", 64'(accepted_count), 64'd0);
`endif
    @(posedge clk); #1;

    // Test 3: almost-full channel 1 parks the word, then drains
    fifo_in_amostfull = 4'b0010;
    drive(6'd9, 32'h5EED_0009);
    sbq.push_back('{1, 32'h5EED_0009});
    @(negedge clk);
    check("t3_ready_accept", 64'(data_in_ready), 64'd1);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("t3_ready_hold", 64'(data_in_ready), 64'd0);
    check("t3_we_hold", 64'(fifo_in_we), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    fifo_in_amostfull = 4'b0000;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (fifo_in_we[1] === 1'b1) begin
        got = 1'b1;
        check("t3_ready_after_drain", 64'(data_in_ready), 64'd1);
      end
    end
    check("t3_drained", 64'(got), 64'd1);
    @(negedge clk);
    check("t3_single_pulse", 64'(fifo_in_we), 64'd0);
    @(posedge clk); #1;

    // Test 4: start=0 blocks accepts but a held word still drains
    fifo_in_amostfull = 4'b0100;
    drive(6'd10, 32'h4444_000A);
    sbq.push_back('{2, 32'h4444_000A});
    @(negedge clk);
    check("t4_ready_accept", 64'(data_in_ready), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    drive(6'd8, 32'h4B4B_0008);
    @(negedge clk);
    check("t4_ready_start0", 64'(data_in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    fifo_in_amostfull = 4'b0000;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (fifo_in_we[2] === 1'b1) got = 1'b1;
    end
    check("t4_drained_start0", 64'(got), 64'd1);
    @(negedge clk);
    check("t4_ready_still0", 64'(data_in_ready), 64'd0);
    check("t4_no_write", 64'(fifo_in_we), 64'd0);
    @(posedge clk); #1;
    start = 1'b1;
    sbq.push_back('{0, 32'h4B4B_0008});
    @(negedge clk);
    check("t4_ready_start1", 64'(data_in_ready), 64'd1);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("t4_we_ch0", 64'(fifo_in_we), 64'd1);
    @(posedge clk); #1;

    // Test 5: reset while channel 2 holds a word discards it
    fifo_in_amostfull = 4'b0100;
    drive(6'd10, 32'hDEAD_000A);
    @(negedge clk);
    check("t5_ready_accept", 64'(data_in_ready), 64'd1);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("t5_ready_hold", 64'(data_in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fifo_in_amostfull = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_we_after_reset", 64'(fifo_in_we), 64'd0);
    check("t5_ready_after_reset", 64'(data_in_ready), 64'd1);
    got = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (fifo_in_we !== '0) got = 1'b1;
    end
    check("t5_no_stale_write", 64'(got), 64'd0);
    @(posedge clk); #1;

    // Test 6: random traffic against the scoreboard
    do_reset();
    have_word = 1'b0;
    cur_id = '0;
    cur_pay = '0;
    for (int n = 0; n < 10000; n++) begin
      if (!have_word && ($urandom_range(0, 9) < 7)) begin
        have_word = 1'b1;
        cur_id  = 6'($urandom_range(6, 13));
        cur_pay = $urandom;
      end
      data_in_valid = have_word;
      data_in = {cur_pay, cur_id};
      for (int c = 0; c < NCH; c++) begin
        fifo_in_amostfull[c] = ($urandom_range(0, 3) == 0);
        fifo_in_full[c] = fifo_in_amostfull[c] & ($urandom_range(0, 1) == 1);
      end
      start = ($urandom_range(0, 19) != 0);
      @(negedge clk);
      if (data_in_valid && data_in_ready === 1'b1) begin
        if (mapped(cur_id)) begin
          sbq.push_back('{int'(cur_id) - IDB, cur_pay});
          exp_acc++;
        end else begin
          exp_drop++;
        end
        have_word = 1'b0;
      end
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    fifo_in_full = '0;
    fifo_in_amostfull = '0;
    start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_all_delivered", 64'(sbq.size()), 64'd0);
    check("t6_ready_idle", 64'(data_in_ready), 64'd1);
`ifdef CTRL_FIFO_STATS_EN
    check("t6_acc", 64'(accepted_count), 64'(exp_acc));
    check("t6_drop", 64'(dropped_count), 64'(exp_drop));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
